// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS pipeline registers.
//   CTRL_W              width of the control bundle
//   CTRL_* indices      bit positions inside the control bundle, laid out as
//                       {regWrite, memRead, memWrite, memToReg, aluSrc,
//                        regDst, branch, aluOp[2:0]}
//   REG_ZERO            architectural zero register index
//   CTRL_NOP            control bundle of a bubble (no side effects)
package mips_pkg;

  localparam int CTRL_W = 10;

  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUOP_MSB = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  localparam logic [4:0]        REG_ZERO = 5'd0;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/idex_hazard_detect.sv
// idex_hazard_detect: combinational load-use hazard detection.
//   ex_valid, ex_mem_read, ex_rt  instruction currently in EX
//   id_valid, id_rs, id_rt        instruction currently in ID
//   flush                         taken branch squashes the ID instruction
//   ex_hold                       EX cannot accept this cycle
//   load_use                      ID reads the register a load in EX produces
//   stall_out                     hold PC and IF/ID this cycle
module idex_hazard_detect
  import mips_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  input  logic       ex_hold,
  output logic       load_use,
  output logic       stall_out
);

  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rt != REG_ZERO) & id_valid &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
    // A flushed ID instruction is discarded anyway, so no need to stall it.
    stall_out = ex_hold | (load_use & ~flush);
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion,
// writeback bypass, branch flush and downstream hold.
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_*                     decoded instruction fields from ID
//   wb_*                     register-file write happening this cycle
//   flush                    squash the incoming ID instruction
//   ex_hold                  EX cannot accept; freeze all registers
//   stall_out                hold PC and IF/ID this cycle
//   ex_*                     registered fields presented to EX
// Optional macro IDEX_PERF_CNT_EN adds saturating 32-bit counters
//   stall_cnt (load-use stalls) and bubble_cnt (inserted bubbles).
//
// Handshake: id_valid qualifies the ID fields; the stage accepts them on a
// rising edge only when ex_hold=0 and stall_out=0. ex_valid qualifies ex_*
// and stays constant while ex_hold=1. A flush seen while ex_hold=1 is lost,
// so the branch unit must keep flush asserted until the hold drops.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_read_data_1,
  input  logic [DATA_W-1:0] id_read_data_2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              load_use;
  logic              byp_a, byp_b;
  logic              bubble;

  idex_hazard_detect u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEMREAD]),
    .ex_rt       (rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .flush       (flush),
    .ex_hold     (ex_hold),
    .load_use    (load_use),
    .stall_out   (stall_out)
  );

  // The register file is written at the same edge this stage captures, so
  // the read port still shows the old value; forward the WB data instead.
  assign byp_a = wb_regWrite & (wb_write_reg != REG_ZERO) & (wb_write_reg == id_rs);
  assign byp_b = wb_regWrite & (wb_write_reg != REG_ZERO) & (wb_write_reg == id_rt);

  assign bubble = ~ex_hold & (flush | load_use);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (ex_hold) begin
      // keep everything
    end else if (flush | load_use) begin
      valid_d = 1'b0;
      pc_d    = '0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      ctrl_d  = CTRL_NOP;
    end else begin
      valid_d = id_valid;
      pc_d    = id_pc;
      a_d     = byp_a ? wb_write_data : id_read_data_1;
      b_d     = byp_b ? wb_write_data : id_read_data_2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      ctrl_d  = id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_pc    = pc_q;
  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_imm   = imm_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;
  assign ex_ctrl  = ctrl_q;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_use & ~flush & ~ex_hold & (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bubble & (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Pipeline register between decode (register-file read) and execute in the 5-stage MIPS pipeline.
- Captures operands, immediate, register indices and control bundle from ID; presents them to EX one cycle later.
- Integrates load-use hazard detection: stalls IF/ID and inserts a bubble.
- Integrates a writeback bypass for the same-cycle register-file write/read race.
- Handles branch flush and downstream hold.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- CTRL_W, 10, control bundle width (layout in mips_pkg)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC+4 of ID instruction
- id_rs, id_rt, id_rd  in  5 each  register indices
- id_read_data_1, id_read_data_2  in  DATA_W  register-file outputs
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  control bundle {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, branch, aluOp[2:0]}
- wb_regWrite  in  1  WB stage writes this cycle
- wb_write_reg  in  5  WB destination
- wb_write_data  in  DATA_W  WB data
- flush  in  1  taken branch/jump; squash incoming ID instruction
- ex_hold  in  1  EX cannot accept; freeze stage
- stall_out  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_a, ex_b, ex_imm  out  DATA_W  registered fields
- ex_rs, ex_rt, ex_rd  out  5 each  registered indices
- ex_ctrl  out  CTRL_W  registered control; all-zero when ex_valid=0

Behaviour:
- Reset: all ex_* outputs 0, ex_valid=0. stall_out is combinational and evaluates to 0 while registers are 0 and ex_hold=0. Reset mid-stall clears the bubble state; the next cycle loads normally.
- Latency: 1 cycle ID->EX.
- Load-use detect, combinational: load_use = ex_valid & ex_ctrl.memRead & (ex_rt!=0) & id_valid & (ex_rt==id_rs | ex_rt==id_rt).
- stall_out = ex_hold | (load_use & ~flush).
- Per-edge priority:
  - rst: clear all.
  - ex_hold: keep all registers.
  - flush: bubble (ex_valid=0, ex_ctrl=0, data fields don't-care but driven 0).
  - load_use: bubble.
  - else: load ID fields, ex_valid=id_valid, ex_ctrl = id_valid ? id_ctrl : 0.
- Bubble lasts exactly one cycle. The next cycle the load has left EX, so load_use deasserts and the stalled instruction loads.
- WB bypass on load only:
  - ex_a <= (wb_regWrite & wb_write_reg!=0 & wb_write_reg==id_rs) ? wb_write_data : id_read_data_1. Same rule for ex_b with id_rt.
  - Register 0 is never bypassed.
  - rs==rt: both operands take bypass data.
- flush with load_use: flush wins; stall_out=0.
- flush with ex_hold: hold wins; flush must be re-asserted by the branch unit (documented contract).
- id_valid=0 with matching indices: no stall.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- With it defined:
  - Ports stall_cnt and bubble_cnt, 32-bit outputs.
  - stall_cnt increments on cycles with load_use & ~flush & ~ex_hold.
  - bubble_cnt increments on every inserted bubble (flush or load-use).
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Without it: ports and logic absent; behaviour otherwise identical.

Decomposition:
- mips_pkg holds: CTRL_W, control bit indices (CTRL_REGWRITE ... CTRL_ALUOP_LSB), REG_ZERO=5'd0, NOP control constant.
- One sub-module, idex_hazard_detect: combinational load_use and stall_out.
- Bypass muxes and registers stay in id_ex_pipe.

Test Plan:
1. Normal load: id_valid=1, rs=2, rt=3, read_data 0x11/0x22, imm=0x5, ctrl regWrite|aluSrc -> next cycle ex_a=0x11, ex_b=0x22, ex_imm=5, ex_valid=1, stall_out=0 throughout.
2. Load-use: EX holds lw with rt=5; ID instr rs=5 -> stall_out=1 that cycle; next edge ex_valid=0, ex_ctrl=0; following cycle stall_out=0 and instr loads with its operands.
3. rt=0 load, ID uses r0 -> no stall; ex_valid=1 next cycle.
4. WB bypass: wb_regWrite=1, wb_write_reg=7, wb_write_data=55; ID rs=7, rt=7, read_data stale 0 -> ex_a=ex_b=55. Same with wb_write_reg=0 -> ex_a=ex_b=0 from regfile.
5. Flush during load_use -> stall_out=0, bubble inserted. ex_hold=1 for 3 cycles -> ex_* unchanged, stall_out=1 each cycle.
6. rst asserted mid-stall -> all ex_* 0 next edge. With IDEX_PERF_CNT_EN: after tests 2 and 5, stall_cnt=1, bubble_cnt=2.
